uart_bps_gen: RTL and testbench
===============================

Name: uart_bps_gen

Overview:
- Parametrised baud-rate tick generator; successor to the fixed-rate half-bit generator in the UART loopback path.
- Serves both the UART RX and TX datapaths.
- Adds a runtime-programmable divisor with glitch-free shadow update, a full-bit tick alongside the mid-bit tick, a frame bit counter with frame-done, and continuous (back-to-back frame) mode.

Parameters:
- CNT_W, 16: width of divisor and bit-period counter.
- DIV_DEFAULT, 2604: reset divisor in clk cycles per bit (25 MHz / 9600). Must be ≥2 and < 2^CNT_W.
- FRAME_BITS, 10: bit periods per frame (start + 8 data + stop). Range 1..255.
- IDX_W, 4: width of bit_idx. Must satisfy 2^IDX_W ≥ FRAME_BITS.

Ports:
- clk, in, 1: single clock; all logic on the rising edge.
- rst, in, 1: synchronous, active-high reset.
- start, in, 1: begin a frame. Honoured only in IDLE.
- abort, in, 1: stop immediately and return to IDLE.
- cont, in, 1: sampled at each frame end; 1 = start the next frame with no gap.
- div_wr, in, 1: write strobe for div_in.
- div_in, in, CNT_W: new divisor (clk cycles per bit).
- busy, out, 1: high while in RUN.
- bit_tick, out, 1: one-cycle pulse at the end of each bit period.
- mid_tick, out, 1: one-cycle pulse at the middle of each bit period (RX sample point).
- bit_idx, out, IDX_W: index of the current bit within the frame, 0..FRAME_BITS-1.
- frame_done, out, 1: one-cycle pulse, coincident with the bit_tick of the last bit.
- div_cur, out, CNT_W: divisor currently in use.

Behaviour:
- Reset (rst=1 at an edge):
  - state=IDLE, cnt=0, bit_idx=0.
  - busy, bit_tick, mid_tick and frame_done are 0.
  - div_cur=DIV_DEFAULT; the shadow divisor and its pending flag are cleared.
  - Applies identically in the middle of a frame.
- Divisor clamp: any div_in <2 is stored as 2. H = div_cur>>1 (floor).
- Divisor write:
  - In IDLE: div_cur takes the clamped div_in at the same edge.
  - In RUN: the value goes to the shadow register and pending is set. A later write while pending overwrites the shadow.
  - The shadow is copied to div_cur, and pending cleared, at the edge that ends the frame (frame_done edge), or at the edge where abort is taken.
- States:
  - IDLE: start=1 and abort=0 → RUN, cnt=0, bit_idx=0. start is ignored while in RUN.
  - RUN: cnt increments each cycle.
    - At the edge where cnt==div_cur-1: cnt←0, bit_tick←1, bit_idx advances.
    - At the edge where cnt==H-1: mid_tick←1.
    - On the last bit (bit_idx==FRAME_BITS-1), the bit_tick edge also sets frame_done←1 and bit_idx←0.
    - If cont=1 at that edge, stay in RUN; the next frame's cnt starts at 0. Otherwise go to IDLE.
  - abort=1 in RUN → IDLE at that edge, cnt=0, bit_idx=0. No tick or frame_done is generated at that edge, even if a terminal count coincides.
- Timing (all outputs registered): start sampled at edge E0 (state becomes RUN after E0).
  - mid_tick is high during the cycle after edge E(H).
  - bit_tick is high during the cycle after edge E(div_cur); repeats every div_cur cycles.
  - bit_idx changes together with bit_tick.
  - A frame spans exactly FRAME_BITS×div_cur cycles.
  - busy rises after E0 and falls after the final edge of the frame.
- With div_cur=2 (H=1), mid_tick and bit_tick alternate every cycle.
- Simultaneous events:
  - abort + start in IDLE → stay in IDLE.
  - div_wr on the frame_done edge → the new value applies to the next frame.
  - rst has priority over everything.

Test Plan:
- rst, then start with DIV_DEFAULT=4, FRAME_BITS=3, cont=0 → mid_tick after E2, E6, E10; bit_tick after E4, E8, E12; bit_idx 0→1→2→0; frame_done after E12 only; busy high E0..E12, then 0.
- div_wr with div_in=1 in IDLE → div_cur=2; start → ticks alternate mid/bit every cycle; frame lasts 6 cycles (FRAME_BITS=3).
- div_wr with div_in=8 during a frame at div 4 → current frame keeps period 4; div_cur=8 after the frame_done edge; the next start gives a bit period of 8.
- cont=1 for two frames at div 4 → 24 contiguous cycles, bit_tick every 4 cycles with no gap, two frame_done pulses, busy held high throughout.
- abort on the same edge as a terminal count in bit 1 → no bit_tick or frame_done; IDLE; bit_idx=0; a pending divisor is applied.
- rst asserted mid-frame with pending=1 → all outputs 0; div_cur=DIV_DEFAULT; the shadow divisor is discarded.

Source files
------------

// File: rtl/uart_bps_if.sv
// Control/status bundle between a UART datapath and its baud-rate tick generator.
interface uart_bps_if #(
  parameter int CNT_W = 16,
  parameter int IDX_W = 4
);
  logic             start;
  logic             abort;
  logic             cont;
  logic             div_wr;
  logic [CNT_W-1:0] div_in;
  logic             busy;
  logic             bit_tick;
  logic             mid_tick;
  logic [IDX_W-1:0] bit_idx;
  logic             frame_done;
  logic [CNT_W-1:0] div_cur;

  // Datapath side: requests frames and programs the divisor.
  modport master (
    output start, abort, cont, div_wr, div_in,
    input  busy, bit_tick, mid_tick, bit_idx, frame_done, div_cur
  );

  // Generator side.
  modport slave (
    input  start, abort, cont, div_wr, div_in,
    output busy, bit_tick, mid_tick, bit_idx, frame_done, div_cur
  );
endinterface

// File: rtl/uart_bps_gen.sv
// Baud-rate tick generator: mid-bit and end-of-bit ticks, frame bit index,
// frame-done pulse, back-to-back frames and a shadowed runtime divisor.
module uart_bps_gen #(
  parameter int CNT_W       = 16,
  parameter int DIV_DEFAULT = 2604,
  parameter int FRAME_BITS  = 10,
  parameter int IDX_W       = 4
) (
  input logic     clk,
  input logic     rst,
  uart_bps_if.slave bus
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] DIV_MIN  = CNT_W'(2);
  localparam logic [CNT_W-1:0] DIV_RST  = CNT_W'(DIV_DEFAULT);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FRAME_BITS - 1);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [IDX_W-1:0] idx_reg, idx_next;
  logic             bit_tick_reg, bit_tick_next;
  logic             mid_tick_reg, mid_tick_next;
  logic             frame_done_reg, frame_done_next;
  logic [CNT_W-1:0] div_cur_reg, div_cur_next;
  logic [CNT_W-1:0] shadow_reg, shadow_next;
  logic             pending_reg, pending_next;

  logic [CNT_W-1:0] div_clamped;
  logic [CNT_W-1:0] half_div;
  logic             div_apply;

  // A divisor below 2 would leave no room for a distinct mid-bit point.
  assign div_clamped = (bus.div_in < DIV_MIN) ? DIV_MIN : bus.div_in;
  assign half_div    = div_cur_reg >> 1;

  // State register and all registered outputs; rst wins over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      idx_reg        <= '0;
      bit_tick_reg   <= 1'b0;
      mid_tick_reg   <= 1'b0;
      frame_done_reg <= 1'b0;
      div_cur_reg    <= DIV_RST;
      shadow_reg     <= '0;
      pending_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      idx_reg        <= idx_next;
      bit_tick_reg   <= bit_tick_next;
      mid_tick_reg   <= mid_tick_next;
      frame_done_reg <= frame_done_next;
      div_cur_reg    <= div_cur_next;
      shadow_reg     <= shadow_next;
      pending_reg    <= pending_next;
    end
  end

  // Next-state, bit counting, tick generation and divisor shadow handling.
  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    idx_next        = idx_reg;
    bit_tick_next   = 1'b0;
    mid_tick_next   = 1'b0;
    frame_done_next = 1'b0;
    div_cur_next    = div_cur_reg;
    shadow_next     = shadow_reg;
    pending_next    = pending_reg;
    div_apply       = 1'b0;

    case (state_reg)
      IDLE: begin
        if (bus.start && !bus.abort) begin
          state_next = RUN;
          cnt_next   = '0;
          idx_next   = '0;
        end
      end
      RUN: begin
        if (bus.abort) begin
          // Abort suppresses any tick that would have landed on this edge.
          state_next = IDLE;
          cnt_next   = '0;
          idx_next   = '0;
          div_apply  = 1'b1;
        end else begin
          if (cnt_reg == half_div - CNT_ONE) begin
            mid_tick_next = 1'b1;
          end
          if (cnt_reg == div_cur_reg - CNT_ONE) begin
            cnt_next      = '0;
            bit_tick_next = 1'b1;
            if (idx_reg == IDX_LAST) begin
              idx_next        = '0;
              frame_done_next = 1'b1;
              div_apply       = 1'b1;
              if (!bus.cont) begin
                state_next = IDLE;
              end
            end else begin
              idx_next = idx_reg + IDX_ONE;
            end
          end else begin
            cnt_next = cnt_reg + CNT_ONE;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // Divisor only changes between frames so a running frame keeps its period.
    if (div_apply && pending_reg) begin
      div_cur_next = shadow_reg;
      pending_next = 1'b0;
    end
    if (bus.div_wr) begin
      if (state_reg == IDLE || div_apply) begin
        div_cur_next = div_clamped;
      end else begin
        shadow_next  = div_clamped;
        pending_next = 1'b1;
      end
    end
  end

  assign bus.busy       = (state_reg == RUN);
  assign bus.bit_tick   = bit_tick_reg;
  assign bus.mid_tick   = mid_tick_reg;
  assign bus.bit_idx    = idx_reg;
  assign bus.frame_done = frame_done_reg;
  assign bus.div_cur    = div_cur_reg;

endmodule

// File: tb/tb_uart_bps_gen.sv
// Self-checking bench for uart_bps_gen: directed steps followed by random
// traffic, every cycle compared against an arithmetic frame-position model.
module tb_uart_bps_gen;

  localparam int CNT_W       = 16;
  localparam int IDX_W       = 4;
  localparam int DIV_DEFAULT = 4;
  localparam int FRAME_BITS  = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  uart_bps_if #(.CNT_W(CNT_W), .IDX_W(IDX_W)) bus ();

  uart_bps_gen #(
    .CNT_W(CNT_W),
    .DIV_DEFAULT(DIV_DEFAULT),
    .FRAME_BITS(FRAME_BITS),
    .IDX_W(IDX_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: position k (edges since frame start) and frame divisor d.
  int m_run, m_k, m_d, m_div, m_pend, m_shadow;
  int e_busy, e_bit, e_mid, e_idx, e_fd;

  // Observed-pulse tallies for directed checks.
  int t_bit, t_mid, t_fd, t_busy;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_update();
    int  cl;
    bit  apply, was_run, newf;
    if (rst) begin
      m_run = 0; m_k = 0; m_d = DIV_DEFAULT; m_div = DIV_DEFAULT;
      m_pend = 0; m_shadow = 0;
      e_busy = 0; e_bit = 0; e_mid = 0; e_idx = 0; e_fd = 0;
      return;
    end
    cl      = (bus.div_in < 2) ? 2 : int'(bus.div_in);
    apply   = 0;
    newf    = 0;
    was_run = (m_run != 0);
    e_bit = 0; e_mid = 0; e_idx = 0; e_fd = 0;
    if (!was_run) begin
      if (bus.start && !bus.abort) begin
        m_run = 1;
        newf  = 1;
      end
    end else if (bus.abort) begin
      m_run = 0;
      apply = 1;
    end else begin
      m_k++;
      e_bit = (m_k % m_d == 0) ? 1 : 0;
      e_mid = (m_k % m_d == m_d / 2) ? 1 : 0;
      e_idx = (m_k / m_d) % FRAME_BITS;
      if (m_k == FRAME_BITS * m_d) begin
        e_fd  = 1;
        apply = 1;
        if (bus.cont) newf = 1;
        else          m_run = 0;
      end
    end
    if (apply && m_pend != 0) begin
      m_div  = m_shadow;
      m_pend = 0;
    end
    if (bus.div_wr) begin
      if (!was_run || apply) m_div = cl;
      else begin
        m_shadow = cl;
        m_pend   = 1;
      end
    end
    if (newf) begin
      m_k = 0;
      m_d = m_div;
    end
    e_busy = m_run;
  endtask

  // One clock: model sees the same inputs as the DUT, outputs checked 1 ns later.
  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    chk("busy",       32'(bus.busy),       32'(e_busy));
    chk("bit_tick",   32'(bus.bit_tick),   32'(e_bit));
    chk("mid_tick",   32'(bus.mid_tick),   32'(e_mid));
    chk("bit_idx",    32'(bus.bit_idx),    32'(e_idx));
    chk("frame_done", 32'(bus.frame_done), 32'(e_fd));
    chk("div_cur",    32'(bus.div_cur),    32'(m_div));
    if (bus.bit_tick   === 1'b1) t_bit++;
    if (bus.mid_tick   === 1'b1) t_mid++;
    if (bus.frame_done === 1'b1) t_fd++;
    if (bus.busy       === 1'b1) t_busy++;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic clr_tally();
    t_bit = 0; t_mid = 0; t_fd = 0; t_busy = 0;
  endtask

  task automatic write_div(input int v);
    bus.div_wr = 1'b1;
    bus.div_in = CNT_W'(v);
    step();
    bus.div_wr = 1'b0;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  initial begin
    bus.start  = 1'b0;
    bus.abort  = 1'b0;
    bus.cont   = 1'b0;
    bus.div_wr = 1'b0;
    bus.div_in = '0;
    clr_tally();

    // Reset state
    rst = 1'b1;
    steps(2);
    rst = 1'b0;
    chk("rst_div_cur", 32'(bus.div_cur), 32'(DIV_DEFAULT));
    chk("rst_busy", 32'(bus.busy), 32'd0);
    $display("step reset: checks=%0d", n_checks);

    // Single frame at divisor 4
    clr_tally();
    pulse_start();
    steps(14);
    chk("t1_bits", 32'(t_bit), 32'd3);
    chk("t1_mids", 32'(t_mid), 32'd3);
    chk("t1_fd", 32'(t_fd), 32'd1);
    chk("t1_busy", 32'(t_busy), 32'd12);
    $display("step single frame div4: checks=%0d", n_checks);

    // Divisor 1 clamps to 2; ticks alternate
    write_div(1);
    chk("t2_clamp", 32'(bus.div_cur), 32'd2);
    clr_tally();
    pulse_start();
    steps(8);
    chk("t2_bits", 32'(t_bit), 32'd3);
    chk("t2_mids", 32'(t_mid), 32'd3);
    chk("t2_busy", 32'(t_busy), 32'd6);
    $display("step clamp div2: checks=%0d", n_checks);

    // Write divisor during a frame; applies at frame end
    write_div(4);
    clr_tally();
    pulse_start();
    steps(4);
    write_div(8);
    chk("t3_shadow_hold", 32'(bus.div_cur), 32'd4);
    steps(10);
    chk("t3_bits_old", 32'(t_bit), 32'd3);
    chk("t3_div_new", 32'(bus.div_cur), 32'd8);
    clr_tally();
    pulse_start();
    steps(26);
    chk("t3_busy_new", 32'(t_busy), 32'd24);
    chk("t3_bits_new", 32'(t_bit), 32'd3);
    $display("step shadow divisor: checks=%0d", n_checks);

    // Two back-to-back frames at divisor 4
    write_div(4);
    clr_tally();
    bus.cont = 1'b1;
    pulse_start();
    steps(12);
    bus.cont = 1'b0;
    steps(14);
    chk("t4_busy", 32'(t_busy), 32'd24);
    chk("t4_fd", 32'(t_fd), 32'd2);
    chk("t4_bits", 32'(t_bit), 32'd6);
    $display("step continuous frames: checks=%0d", n_checks);

    // Abort on the terminal count of bit 1 with a pending divisor
    clr_tally();
    pulse_start();
    steps(4);
    write_div(6);
    steps(2);
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    chk("t5_busy", 32'(bus.busy), 32'd0);
    chk("t5_idx", 32'(bus.bit_idx), 32'd0);
    chk("t5_div", 32'(bus.div_cur), 32'd6);
    steps(3);
    chk("t5_bits", 32'(t_bit), 32'd1);
    chk("t5_fd", 32'(t_fd), 32'd0);
    $display("step abort on terminal count: checks=%0d", n_checks);

    // Reset mid-frame discards the pending divisor
    pulse_start();
    steps(3);
    write_div(9);
    steps(3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t6_div", 32'(bus.div_cur), 32'(DIV_DEFAULT));
    chk("t6_busy", 32'(bus.busy), 32'd0);
    pulse_start();
    steps(14);
    chk("t6_div_after", 32'(bus.div_cur), 32'(DIV_DEFAULT));
    $display("step reset mid-frame: checks=%0d", n_checks);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      rst        = ($urandom_range(0, 499) == 0);
      bus.start  = ($urandom_range(0, 7) == 0);
      bus.abort  = ($urandom_range(0, 63) == 0);
      bus.cont   = $urandom_range(0, 1) == 1;
      bus.div_wr = ($urandom_range(0, 31) == 0);
      bus.div_in = CNT_W'($urandom_range(0, 7));
      step();
    end
    rst        = 1'b0;
    bus.start  = 1'b0;
    bus.abort  = 1'b0;
    bus.cont   = 1'b0;
    bus.div_wr = 1'b0;
    $display("step random traffic: checks=%0d", n_checks);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
